port_tx_frame_arbiter: RTL
==========================

// Module: port_tx_frame_arbiter
// PURPOSE
// - Shares one egress port's tx frame FIFO between NUM_REQ ingress requesters of the FIFO matrix.
// - Grants whole Ethernet frames round-robin; bytes pass through on a valid/ready byte stream.
// - Sits between the fifo_matrix tx rows and the per-port async tx data FIFO write side.
// - Caps frame length: overlong frames are truncated, and their tail is drained.
// PARAMETERS
// - NUM_REQ, default 4: number of requesters (ingress ports), >=2.
// - DATA_W, default 8: byte lane width (BYTE_WIDTH).
// - MAX_FRAME_BYTES, default 1518: longest frame forwarded before truncation.
// PORTS
// - clk             in   1              system clock; single clock domain
// - reset_n         in   1              asynchronous active-low reset
// - req_valid       in   NUM_REQ        per-requester byte valid
// - req_data        in   NUM_REQ*DATA_W per-requester byte, requester i at [i*DATA_W +: DATA_W]
// - req_last        in   NUM_REQ        per-requester last byte of frame
// - req_ready       out  NUM_REQ        per-requester ready; one-hot or zero
// - out_valid       out  1              egress byte valid
// - out_data        out  DATA_W         egress byte
// - out_last        out  1              egress last byte (true or forced by truncation)
// - out_ready       in   1              egress FIFO accepts a byte
// - out_prog_full   in   1              egress FIFO cannot take a maximum-size frame
// - trunc_pulse     out  1              1-cycle pulse: a frame was truncated
// - grant_idx       out  $clog2(NUM_REQ) index of the current/last granted requester
// BEHAVIOUR
// - Reset values: state=IDLE, rr_ptr=0, grant_idx=0, byte_cnt=0; all outputs 0.
// - Handshake: a byte moves when valid & ready are both high in the same cycle.
// - IDLE: when !out_prog_full and any req_valid is high, pick the first valid requester at or after rr_ptr.
//   - Register the pick as grant_idx, go to XFER next cycle. No bytes move in IDLE.
// - XFER: out_valid/out_data/out_last are combinational from the granted requester (0-cycle mux).
//   - req_ready[grant_idx] = out_ready; all other req_ready bits stay 0.
//   - byte_cnt increments on each egress handshake.
//   - On a handshake with req_last: rr_ptr = grant_idx+1 (wraps NUM_REQ-1 -> 0), byte_cnt=0, go to IDLE.
//   - On a handshake where byte_cnt == MAX_FRAME_BYTES-1 and !req_last:
//     - force out_last=1 on that byte, pulse trunc_pulse next cycle, go to DRAIN.
// - DRAIN: out_valid=0; req_ready[grant_idx]=1; discard bytes until a handshake with req_last.
//   - Then rr_ptr advance, byte_cnt=0, go to IDLE.
// - Frame atomicity: a grant is never revoked mid-frame. prog_full is sampled only in IDLE.
// - Minimum 1 idle cycle between frames. Back-to-back frames from one requester must wait its rr turn.
// - A requester dropping req_valid mid-frame stalls the egress (out_valid=0); no timeout.
// - byte_cnt is $clog2(MAX_FRAME_BYTES+1) bits and never wraps.
// - Async reset mid-frame: return to IDLE immediately. The partial egress frame is not terminated;
//   the downstream FIFO reset handles it.
// CONFIGURATION
// - PORT_TX_STATS_EN defined:
//   - Add out port frame_cnt [NUM_REQ*32]: per-requester count of completed frames (XFER last or DRAIN end).
//   - Add out port trunc_cnt [32]: count of truncations.
//   - Counters reset to 0, wrap at 2^32.
// - PORT_TX_STATS_EN undefined: neither port nor counters exist; all other behaviour is identical.
// STRUCTURE
// - switch_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_DRAIN} arb_state_t
//   - localparam MAX_ETHERNET_FRAME_BYTES, BYTE_WIDTH
// - Sub-module rr_pick: combinational round-robin first-set search of req_valid from rr_ptr;
//   outputs idx and found.
// TESTING
// - Single frame: req 2 sends 64 bytes, out_ready=1 -> grant_idx=2 after 1 cycle; 64 out bytes, out_last on byte 64; rr_ptr=3.
// - Round-robin: all 4 requesters hold 10-byte frames -> frame order 0,1,2,3,0; one idle cycle between frames.
// - Back-pressure: out_ready toggles 1,0 each cycle -> req_ready mirrors out_ready; bytes in order; no loss or duplication.
// - prog_full: out_prog_full=1 with req 1 valid -> stays IDLE; 5 cycles after deassert -> XFER begins the next cycle.
// - Truncation: MAX_FRAME_BYTES=16, 20-byte frame -> 16 out bytes, last on the 16th, trunc_pulse once, 4 bytes drained, then IDLE.
// - Reset mid-XFER: reset_n low at byte 7 -> all outputs 0 and IDLE; after release, rr_ptr=0 and arbitration restarts from req 0.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg: shared egress-path types, frame constants and a wrap helper
package switch_pkg;
  localparam int MAX_ETHERNET_FRAME_BYTES = 1518;
  localparam int BYTE_WIDTH = 8;
  typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_DRAIN} arb_state_t;
  function automatic int wrap_inc(int v, int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/port_tx_frame_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-set search of req starting at ptr
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);
  // scan offsets from far to near so the closest set bit at or after ptr wins
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[IW'((int'(ptr) + k) % N)]) begin
        idx = IW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/port_tx_frame_arbiter.sv
// port_tx_frame_arbiter: whole-frame round-robin arbiter onto one egress byte stream with length cap; PORT_TX_STATS_EN adds frame/truncation counters
module port_tx_frame_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = BYTE_WIDTH,
  parameter int MAX_FRAME_BYTES = MAX_ETHERNET_FRAME_BYTES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  input  logic                       out_prog_full,
  output logic                       trunc_pulse,
`ifdef PORT_TX_STATS_EN
  output logic [NUM_REQ*32-1:0]      frame_cnt,
  output logic [31:0]                trunc_cnt,
`endif
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_FRAME_BYTES + 1);
  arb_state_t state;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic [CW-1:0] byte_cnt;
  logic pick_found, sel_valid, sel_last, at_max, xfer_hs, trunc, frame_end;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );
  assign sel_valid = req_valid[grant_idx];
  assign sel_last  = req_last[grant_idx];
  assign at_max    = byte_cnt == CW'(MAX_FRAME_BYTES - 1);
  assign out_valid = (state == ARB_XFER) & sel_valid;
  assign out_data  = (state == ARB_XFER) ? req_data[grant_idx*DATA_W +: DATA_W] : '0;
  assign out_last  = out_valid & (sel_last | at_max);
  assign xfer_hs   = out_valid & out_ready;
  assign trunc     = xfer_hs & at_max & ~sel_last;
  assign frame_end = (xfer_hs & sel_last) | ((state == ARB_DRAIN) & sel_valid & sel_last);
  // only the granted requester sees ready: egress ready while forwarding, always while draining
  always_comb begin
    req_ready = '0;
    req_ready[grant_idx] = (state == ARB_XFER) ? out_ready : (state == ARB_DRAIN);
  end
  // arbitration FSM: pick in IDLE, forward in XFER, discard the overlong tail in DRAIN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      byte_cnt <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      trunc_pulse <= trunc;
      if (state == ARB_IDLE && !out_prog_full && pick_found) begin
        grant_idx <= pick_idx;
        state <= ARB_XFER;
      end
      if (xfer_hs) byte_cnt <= byte_cnt + 1'b1;
      if (trunc) state <= ARB_DRAIN;
      if (frame_end) begin
        rr_ptr <= IW'(wrap_inc(int'(grant_idx), NUM_REQ));
        byte_cnt <= '0;
        state <= ARB_IDLE;
      end
    end
  end
`ifdef PORT_TX_STATS_EN
  // per-requester completed frames and total truncations, free-running wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      if (frame_end) frame_cnt[grant_idx*32 +: 32] <= frame_cnt[grant_idx*32 +: 32] + 32'd1;
      if (trunc) trunc_cnt <= trunc_cnt + 32'd1;
    end
  end
`endif
endmodule
